// File: rtl/vector_mem_sequencer_if.sv
// rtl/vector_mem_sequencer_if.sv - vector register file and word memory port bundle
interface vector_mem_sequencer_if #(
    parameter int N  = 256,
    parameter int W  = 32,
    parameter int AW = 32
);
    logic [4:0]    VA1;
    logic [N-1:0]  VRD1;
    logic [4:0]    VA3;
    logic [N-1:0]  VWD3;
    logic          VWE3;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_ack;

    modport master (
        output VA1, VA3, VWD3, VWE3,
        input  VRD1,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  VA1, VA3, VWD3, VWE3,
        output VRD1,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - serial burst mover between one vector register and word memory
module vector_mem_sequencer #(
    parameter int N  = 256,
    parameter int W  = 32,
    parameter int AW = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_store,
    input  logic [4:0]             vreg_addr,
    input  logic [AW-1:0]          base_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    vector_mem_sequencer_if.master bus
);
    localparam int BEATS = N / W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CAP, S_REQ, S_WB, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] beat;
    logic          op_q;
    logic [4:0]    vreg_q;
    logic [AW-1:0] base_q;
    logic [N-1:0]  buf_q;
    logic          err_q;
    logic          accept;
    logic          last_beat;
    logic          unused_addr_bits;

    // Byte-offset bits of the base address carry no meaning for word transfers.
    assign unused_addr_bits = ^base_addr[1:0];

    assign accept    = (state == S_IDLE) && start && vreg_addr[4];
    assign last_beat = (beat == BW'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = op_store ? S_CAP : S_REQ;
            S_CAP:  state_nxt = S_REQ;
            S_REQ:  if (bus.mem_ack && last_beat) state_nxt = op_q ? S_DONE : S_WB;
            S_WB:   state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat   <= '0;
            op_q   <= 1'b0;
            vreg_q <= '0;
            base_q <= '0;
            buf_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !vreg_addr[4];
            if (accept) begin
                op_q   <= op_store;
                vreg_q <= vreg_addr;
                base_q <= {base_addr[AW-1:2], 2'b00};
                beat   <= '0;
            end
            if (state == S_CAP) buf_q <= bus.VRD1;
            if (state == S_REQ && bus.mem_ack) begin
                beat <= last_beat ? '0 : beat + 1'b1;
                if (!op_q) buf_q[int'(beat)*W +: W] <= bus.mem_rdata;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = err_q;

    assign bus.VA1  = busy ? vreg_q : 5'd0;
    assign bus.VA3  = busy ? vreg_q : 5'd0;
    assign bus.VWE3 = (state == S_WB);
    assign bus.VWD3 = (state == S_WB) ? buf_q : '0;

    // Address and write data are pure functions of held state, so they stay stable across waits.
    assign bus.mem_req   = (state == S_REQ);
    assign bus.mem_we    = bus.mem_req && op_q;
    assign bus.mem_addr  = bus.mem_req ? base_q + (AW'(beat) << 2) : '0;
    assign bus.mem_wdata = (bus.mem_req && op_q) ? buf_q[int'(beat)*W +: W] : '0;
endmodule
